// File: rtl/pump_ctrl_pkg.sv
// Shared definitions for the tank pump controllers: state encoding,
// sensor bit positions and pump indices.
package pump_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    RUN_LEAD   = 3'b001,
    RUN_BOTH   = 3'b010,
    SENSOR_ERR = 3'b100
  } state_t;

  localparam int unsigned I_BIT = 0;
  localparam int unsigned S_BIT = 1;

  localparam int unsigned B1 = 0;
  localparam int unsigned B2 = 1;

  // One-hot pump enable for the selected pump
  function automatic logic [1:0] pump_mask(input logic idx);
    logic [1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/pump_scheduler_if.sv
// Sensor, fault and pump-driver signals between the plant side and the scheduler.
interface pump_scheduler_if;
  logic       tick;
  logic [1:0] level_sensors;
  logic [1:0] pump_fault;
  logic [1:0] pumps;
  logic       lead;
  logic [2:0] current_state;
  logic       alarm;

  modport master (
    output tick, level_sensors, pump_fault,
    input  pumps, lead, current_state, alarm
  );

  modport slave (
    input  tick, level_sensors, pump_fault,
    output pumps, lead, current_state, alarm
  );
endinterface

// File: rtl/tick_counter.sv
// Saturating timebase-tick counter with synchronous clear and async reset.
module tick_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             tick,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Clear has priority so a tick coinciding with a state change is dropped
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pump_scheduler.sv
// Lead/lag pump sequencer with staggered start, minimum off time,
// fault masking and sensor-inconsistency handling.
module pump_scheduler
  import pump_ctrl_pkg::*;
#(
  parameter int unsigned MIN_OFF_TICKS = 4,
  parameter int unsigned STAGGER_TICKS = 2,
  parameter int unsigned CNT_W         = 4
) (
  input logic              clock,
  input logic              reset,
  pump_scheduler_if.slave  bus
);

  state_t           state, state_nx;
  logic             lead_q, lead_nx;
  logic [1:0]       pumps_q, pumps_c;
  logic             alarm_q, alarm_c;
  logic [1:0]       avail;
  logic             eff, lag;
  logic             sens_i, sens_s;
  logic             clear;
  logic [CNT_W-1:0] cnt;

  assign avail  = ~bus.pump_fault;
  assign eff    = avail[lead_q] ? lead_q : ~lead_q;
  assign lag    = ~eff;
  assign sens_i = bus.level_sensors[I_BIT];
  assign sens_s = bus.level_sensors[S_BIT];
  assign clear  = (state_nx != state);

  tick_counter #(.CNT_W(CNT_W)) u_tick_counter (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .tick  (bus.tick),
    .cnt   (cnt)
  );

  // Next state and lead, priority order: sensor error, double fault, completed fill
  always_comb begin
    state_nx = state;
    lead_nx  = lead_q;
    if (bus.level_sensors == 2'b10) begin
      state_nx = SENSOR_ERR;
    end else if (bus.pump_fault == 2'b11) begin
      state_nx = IDLE;
    end else if (((state == RUN_LEAD) || (state == RUN_BOTH)) && sens_s) begin
      state_nx = IDLE;
      lead_nx  = ~lead_q;
    end else begin
      case (state)
        IDLE: begin
          if (!sens_i && (cnt >= CNT_W'(MIN_OFF_TICKS))) state_nx = RUN_LEAD;
        end
        RUN_LEAD: begin
          if (!sens_i && (cnt >= CNT_W'(STAGGER_TICKS)) && avail[lag]) state_nx = RUN_BOTH;
        end
        RUN_BOTH: begin
          if (sens_i || (bus.pump_fault != 2'b00)) state_nx = RUN_LEAD;
        end
        SENSOR_ERR: state_nx = IDLE;
        default:    state_nx = IDLE;
      endcase
    end
  end

  // Output decode from the next state; faulted pumps are always masked off
  always_comb begin
    pumps_c = '0;
    case (state_nx)
      RUN_LEAD: pumps_c = pump_mask(eff) & avail;
      RUN_BOTH: pumps_c = avail;
      default:  pumps_c = '0;
    endcase
    alarm_c = (state_nx == SENSOR_ERR) || (bus.pump_fault == 2'b11);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      lead_q  <= 1'(B1);
      pumps_q <= '0;
      alarm_q <= 1'b0;
    end else begin
      state   <= state_nx;
      lead_q  <= lead_nx;
      pumps_q <= pumps_c;
      alarm_q <= alarm_c;
    end
  end

  assign bus.pumps         = pumps_q;
  assign bus.lead          = lead_q;
  assign bus.current_state = state;
  assign bus.alarm         = alarm_q;

endmodule

// File: tb/tb_pump_scheduler.sv
// Directed scenarios plus randomized traffic checked against a rule-level model.
module tb_pump_scheduler;

  localparam int MIN_OFF = 4;
  localparam int STAG    = 2;
  localparam int CMAX    = 15;
  localparam int M_IDLE  = 0;
  localparam int M_LEAD  = 1;
  localparam int M_BOTH  = 2;
  localparam int M_ERR   = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  pump_scheduler_if bus_if();

  pump_scheduler #(.MIN_OFF_TICKS(4), .STAGGER_TICKS(2), .CNT_W(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model: mode, tick count and lead as plain integers
  int       m_mode, m_cnt, nxt, eff;
  bit       m_lead, tog, s_i, s_s;
  bit [1:0] m_pumps, ok;
  bit       m_alarm;

  function automatic logic [2:0] enc(input int m);
    case (m)
      M_IDLE:  return 3'b000;
      M_LEAD:  return 3'b001;
      M_BOTH:  return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_IDLE; m_cnt = 0; m_lead = 0; m_pumps = 0; m_alarm = 0;
    end else begin
      ok  = ~bus_if.pump_fault;
      s_i = bus_if.level_sensors[0];
      s_s = bus_if.level_sensors[1];
      eff = ok[m_lead] ? int'(m_lead) : 1 - int'(m_lead);
      nxt = m_mode;
      tog = 0;
      if (s_s && !s_i) nxt = M_ERR;
      else if (ok == 2'b00) nxt = M_IDLE;
      else if ((m_mode == M_LEAD || m_mode == M_BOTH) && s_s) begin nxt = M_IDLE; tog = 1; end
      else if (m_mode == M_IDLE) begin if (!s_i && m_cnt >= MIN_OFF) nxt = M_LEAD; end
      else if (m_mode == M_LEAD) begin if (!s_i && m_cnt >= STAG && ok[1-eff]) nxt = M_BOTH; end
      else if (m_mode == M_BOTH) begin if (s_i || ok != 2'b11) nxt = M_LEAD; end
      else nxt = M_IDLE;
      if (nxt != m_mode) m_cnt = 0;
      else if (bus_if.tick && m_cnt < CMAX) m_cnt = m_cnt + 1;
      m_pumps = 2'b00;
      if (nxt == M_LEAD) m_pumps[eff] = ok[eff];
      else if (nxt == M_BOTH) m_pumps = ok;
      m_alarm = (nxt == M_ERR) || (ok == 2'b00);
      if (tog) m_lead = !m_lead;
      m_mode = nxt;
    end
  end

  // One clock with the given tick value; returns at the following falling edge
  task automatic step(input bit t);
    bus_if.tick = t;
    @(negedge clk);
    bus_if.tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus_if.pumps !== 2'b00) begin errors++; $display("FAIL reset_pumps: got %b want 00", bus_if.pumps); end
    checks++; if (bus_if.lead !== 1'b0) begin errors++; $display("FAIL reset_lead: got %b want 0", bus_if.lead); end
    checks++; if (bus_if.current_state !== 3'b000) begin errors++; $display("FAIL reset_state: got %b want 000", bus_if.current_state); end
    checks++; if (bus_if.alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm: got %b want 0", bus_if.alarm); end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    bus_if.level_sensors = 2'b00;
    for (int i = 0; i < MIN_OFF; i++) begin
      step(1);
      checks++; if (bus_if.pumps !== 2'b00) begin errors++; $display("FAIL fill_minoff tick%0d: got %b want 00", i, bus_if.pumps); end
    end
    step(0);
    checks++; if (bus_if.pumps !== 2'b01) begin errors++; $display("FAIL fill_lead: got %b want 01", bus_if.pumps); end
    checks++; if (bus_if.current_state !== 3'b001) begin errors++; $display("FAIL fill_state: got %b want 001", bus_if.current_state); end
    step(1); step(1);
    checks++; if (bus_if.pumps !== 2'b01) begin errors++; $display("FAIL fill_stagger: got %b want 01", bus_if.pumps); end
    step(0);
    checks++; if (bus_if.pumps !== 2'b11) begin errors++; $display("FAIL fill_both: got %b want 11", bus_if.pumps); end
  endtask

  task automatic test_alternation();
    bus_if.level_sensors = 2'b01;
    step(0);
    checks++; if (bus_if.pumps !== 2'b01) begin errors++; $display("FAIL alt_droplag: got %b want 01", bus_if.pumps); end
    bus_if.level_sensors = 2'b11;
    step(0);
    checks++; if (bus_if.pumps !== 2'b00) begin errors++; $display("FAIL alt_stop: got %b want 00", bus_if.pumps); end
    checks++; if (bus_if.lead !== 1'b1) begin errors++; $display("FAIL alt_lead: got %b want 1", bus_if.lead); end
    bus_if.level_sensors = 2'b00;
    for (int i = 0; i < MIN_OFF; i++) step(1);
    checks++; if (bus_if.pumps !== 2'b00) begin errors++; $display("FAIL alt_minoff: got %b want 00", bus_if.pumps); end
    step(0);
    checks++; if (bus_if.pumps !== 2'b10) begin errors++; $display("FAIL alt_b2first: got %b want 10", bus_if.pumps); end
    step(1); step(1); step(0);
    checks++; if (bus_if.pumps !== 2'b11) begin errors++; $display("FAIL alt_both: got %b want 11", bus_if.pumps); end
  endtask

  task automatic test_sensor_err();
    bus_if.level_sensors = 2'b10;
    step(0);
    checks++; if (bus_if.pumps !== 2'b00) begin errors++; $display("FAIL serr_pumps: got %b want 00", bus_if.pumps); end
    checks++; if (bus_if.alarm !== 1'b1) begin errors++; $display("FAIL serr_alarm: got %b want 1", bus_if.alarm); end
    checks++; if (bus_if.current_state !== 3'b100) begin errors++; $display("FAIL serr_state: got %b want 100", bus_if.current_state); end
    checks++; if (bus_if.lead !== 1'b1) begin errors++; $display("FAIL serr_lead: got %b want 1", bus_if.lead); end
    bus_if.level_sensors = 2'b00;
    step(0);
    checks++; if (bus_if.current_state !== 3'b000 || bus_if.alarm !== 1'b0) begin errors++; $display("FAIL serr_clear: got state %b alarm %b want 000 0", bus_if.current_state, bus_if.alarm); end
    for (int i = 0; i < MIN_OFF - 1; i++) step(1);
    step(0);
    checks++; if (bus_if.pumps !== 2'b00) begin errors++; $display("FAIL serr_early: got %b want 00", bus_if.pumps); end
    step(1); step(0);
    checks++; if (bus_if.pumps !== 2'b10) begin errors++; $display("FAIL serr_restart: got %b want 10", bus_if.pumps); end
  endtask

  task automatic test_faults();
    bus_if.level_sensors = 2'b11;
    step(0);
    bus_if.level_sensors = 2'b00;
    for (int i = 0; i < MIN_OFF; i++) step(1);
    step(0);
    checks++; if (bus_if.pumps !== 2'b01 || bus_if.lead !== 1'b0) begin errors++; $display("FAIL flt_setup: got pumps %b lead %b want 01 0", bus_if.pumps, bus_if.lead); end
    bus_if.pump_fault = 2'b01;
    step(0);
    checks++; if (bus_if.pumps !== 2'b10) begin errors++; $display("FAIL flt_redirect: got %b want 10", bus_if.pumps); end
    checks++; if (bus_if.lead !== 1'b0) begin errors++; $display("FAIL flt_lead: got %b want 0", bus_if.lead); end
    bus_if.pump_fault = 2'b11;
    step(0);
    checks++; if (bus_if.pumps !== 2'b00 || bus_if.current_state !== 3'b000) begin errors++; $display("FAIL flt_double: got pumps %b state %b want 00 000", bus_if.pumps, bus_if.current_state); end
    checks++; if (bus_if.alarm !== 1'b1) begin errors++; $display("FAIL flt_alarm: got %b want 1", bus_if.alarm); end
    bus_if.pump_fault = 2'b00;
    step(0);
    checks++; if (bus_if.alarm !== 1'b0) begin errors++; $display("FAIL flt_alarmclr: got %b want 0", bus_if.alarm); end
    for (int i = 0; i < MIN_OFF; i++) step(1);
    step(0);
    checks++; if (bus_if.pumps !== 2'b01) begin errors++; $display("FAIL flt_restart: got %b want 01", bus_if.pumps); end
  endtask

  task automatic test_priority();
    bus_if.level_sensors = 2'b11;
    bus_if.pump_fault    = 2'b11;
    step(0);
    checks++; if (bus_if.current_state !== 3'b000 || bus_if.alarm !== 1'b1) begin errors++; $display("FAIL prio_state: got state %b alarm %b want 000 1", bus_if.current_state, bus_if.alarm); end
    checks++; if (bus_if.lead !== 1'b0) begin errors++; $display("FAIL prio_notoggle: got %b want 0", bus_if.lead); end
    bus_if.pump_fault    = 2'b00;
    bus_if.level_sensors = 2'b00;
    for (int i = 0; i < MIN_OFF; i++) step(1);
    step(0);
    checks++; if (bus_if.pumps !== 2'b01) begin errors++; $display("FAIL prio_restart: got %b want 01", bus_if.pumps); end
  endtask

  task automatic test_async_reset();
    bus_if.level_sensors = 2'b11;
    step(0);
    bus_if.level_sensors = 2'b00;
    for (int i = 0; i < MIN_OFF; i++) step(1);
    step(0); step(1); step(1); step(0);
    checks++; if (bus_if.pumps !== 2'b11 || bus_if.lead !== 1'b1) begin errors++; $display("FAIL arst_setup: got pumps %b lead %b want 11 1", bus_if.pumps, bus_if.lead); end
    rst = 1'b1;
    #1;
    checks++; if (bus_if.pumps !== 2'b00) begin errors++; $display("FAIL arst_pumps: got %b want 00", bus_if.pumps); end
    checks++; if (bus_if.lead !== 1'b0 || bus_if.current_state !== 3'b000) begin errors++; $display("FAIL arst_regs: got lead %b state %b want 0 000", bus_if.lead, bus_if.current_state); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < MIN_OFF; i++) step(1);
    checks++; if (bus_if.pumps !== 2'b00) begin errors++; $display("FAIL arst_minoff: got %b want 00", bus_if.pumps); end
    step(0);
    checks++; if (bus_if.pumps !== 2'b01) begin errors++; $display("FAIL arst_restart: got %b want 01", bus_if.pumps); end
  endtask

  task automatic test_hysteresis();
    do_reset();
    bus_if.level_sensors = 2'b01;
    for (int i = 0; i < 20; i++) begin
      step(1);
      checks++; if (bus_if.pumps !== 2'b00) begin errors++; $display("FAIL hyst tick%0d: got %b want 00", i, bus_if.pumps); end
    end
    do_reset();
    bus_if.level_sensors = 2'b00;
    for (int i = 0; i < 100; i++) step(0);
    checks++; if (bus_if.pumps !== 2'b00 || bus_if.current_state !== 3'b000) begin errors++; $display("FAIL notick: got pumps %b state %b want 00 000", bus_if.pumps, bus_if.current_state); end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        r = int'($urandom_range(0, 99));
        bus_if.level_sensors = (r < 40) ? 2'b00 : (r < 70) ? 2'b01 : (r < 95) ? 2'b11 : 2'b10;
      end
      if ($urandom_range(0, 59) == 0) bus_if.pump_fault = 2'($urandom_range(0, 3));
      else if (bus_if.pump_fault != 2'b00 && $urandom_range(0, 14) == 0) bus_if.pump_fault = 2'b00;
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        #1;
        checks++; if (bus_if.pumps !== 2'b00 || bus_if.current_state !== 3'b000) begin errors++; $display("FAIL rnd_arst n=%0d: got pumps %b state %b want 00 000", n, bus_if.pumps, bus_if.current_state); end
        @(negedge clk);
        rst = 1'b0;
      end
      step(bit'($urandom_range(0, 2) == 0));
      checks++; if (bus_if.pumps !== m_pumps) begin errors++; $display("FAIL rnd_pumps n=%0d: got %b want %b", n, bus_if.pumps, m_pumps); end
      checks++; if (bus_if.lead !== m_lead) begin errors++; $display("FAIL rnd_lead n=%0d: got %b want %b", n, bus_if.lead, m_lead); end
      checks++; if (bus_if.current_state !== enc(m_mode)) begin errors++; $display("FAIL rnd_state n=%0d: got %b want %b", n, bus_if.current_state, enc(m_mode)); end
      checks++; if (bus_if.alarm !== m_alarm) begin errors++; $display("FAIL rnd_alarm n=%0d: got %b want %b", n, bus_if.alarm, m_alarm); end
    end
  endtask

  initial begin
    bus_if.tick          = 1'b0;
    bus_if.level_sensors = 2'b00;
    bus_if.pump_fault    = 2'b00;
    #1;
    test_reset();
    test_fill();
    test_alternation();
    test_sensor_err();
    test_faults();
    test_priority();
    test_async_reset();
    test_hysteresis();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pump_scheduler.md
# pump_scheduler

- Sequences the two tank pumps B1/B2 from the lower (I) and upper (S) level sensors.
- Adds four things to the basic fill controller:
  - lead/lag alternation between fill cycles;
  - a staggered start of the lag pump;
  - a minimum off time between fills;
  - fault and sensor-inconsistency handling.
- Sits between the sensor inputs and the pump drivers and replaces direct sensor-to-pump decoding.
- All timing is measured in ticks of an external timebase strobe.

## Interface
Parameters:
- MIN_OFF_TICKS, 4: ticks the pumps must stay off after a stop, reset or error before a fill may start.
- STAGGER_TICKS, 2: ticks the lead pump must run before the lag pump may join.
- CNT_W, 4: tick counter width. Both tick parameters must be ≤ 2^CNT_W-1.

Ports:
- clock  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- tick  in  1  timebase strobe, one clock wide, synchronous to clock.
- level_sensors  in  2  [0] = I (lower), [1] = S (upper); 1 = water at or above the sensor. Synchronous to clock.
- pump_fault  in  2  [0] = B1 faulted, [1] = B2 faulted; level-sensitive, synchronous.
- pumps  out  2  [0] = B1 on, [1] = B2 on; registered.
- lead  out  1  designated lead pump: 0 = B1, 1 = B2; registered.
- current_state  out  3  state encoding, for debug; registered.
- alarm  out  1  sensor inconsistency or both pumps faulted; registered.

## Operation
States (encoding):
- IDLE = 000
- RUN_LEAD = 001
- RUN_BOTH = 010
- SENSOR_ERR = 100

Definitions:
- avail[i] = ~pump_fault[i].
- Effective lead (eff) = lead if avail[lead], else ~lead. The `lead` register itself does not change when eff is redirected.
- cnt is a saturating tick counter:
  - cleared to 0 on every state change;
  - otherwise increments on tick, saturating at 2^CNT_W-1.

Transition priority, evaluated every clock, first match wins:
1. level_sensors == 2'b10 (S=1 with I=0, physically impossible) → SENSOR_ERR, from any state.
2. pump_fault == 2'b11 → IDLE, from any state.
3. In RUN_LEAD or RUN_BOTH, S=1 → IDLE, and lead toggles. This marks a completed fill.
4. Per-state rules:
   - IDLE → RUN_LEAD when I=0 and cnt ≥ MIN_OFF_TICKS. Hysteresis: a level between I and S never starts a fill.
   - RUN_LEAD → RUN_BOTH when I=0, cnt ≥ STAGGER_TICKS and avail[~eff].
   - RUN_BOTH → RUN_LEAD when I=1. The lag pump is dropped.
   - RUN_BOTH → RUN_LEAD when one pump becomes faulted. The survivor becomes eff.
   - SENSOR_ERR → IDLE when level_sensors != 2'b10. cnt is cleared, so the full minimum off time is enforced again.
   - Otherwise, hold the current state.

Output decode (registered from next state and current pump_fault):
- IDLE and SENSOR_ERR: pumps = 00.
- RUN_LEAD: only the eff bit is set.
- RUN_BOTH: pumps = avail.
- A faulted pump's output is always 0.

alarm:
- 1 while the next state is SENSOR_ERR, or while pump_fault == 11.
- 0 otherwise.

Lead toggle:
- Toggles only on completed-fill stops, even if the new lead pump is faulted.
- Does not toggle on stops caused by a sensor error or by a double fault.

## Timing
- Reset values: current_state = IDLE, cnt = 0, pumps = 00, lead = 0, alarm = 0.
- Because cnt is 0 out of reset, MIN_OFF_TICKS is enforced after every reset.
- Latency: an input sampled at edge k updates current_state, pumps, lead and alarm together at edge k. There is one register stage and no combinational input-to-output path.
- Fault masking takes effect within one clock of pump_fault rising.
- Counter interaction:
  - A tick in the same cycle as a state change is lost (the clear wins).
  - With tick held low, no timed transition ever fires.
- Reset asserted mid-fill forces pumps = 00 asynchronously. No clock edge is required.
- Reset release must be synchronous to clock; this is handled upstream.
- Simultaneous events are resolved by the priority list only. Examples:
  - S=1 together with a new fault: double fault wins over the completed-fill stop.
  - S=1 together with I=0: the sensor error wins.

## Structure
- Shared package pump_ctrl_pkg holds:
  - state encoding constants;
  - sensor bit indices (I_BIT = 0, S_BIT = 1);
  - pump indices (B1 = 0, B2 = 1).
  The existing fsm_sequence logic uses the same package.
- Sub-module tick_counter: CNT_W-bit saturating counter with clear, tick enable and async reset. It is instantiated once.
- Everything else sits in pump_scheduler:
  - next-state logic;
  - eff mux;
  - output decode and output registers.

## Test plan
All scenarios use default parameters.
1. Reset, sensors 00, no faults → pumps = 00 for 4 ticks, then 01 (current_state = 001). After 2 more ticks, pumps = 11.
2. In RUN_BOTH:
   - set sensors 01 → pumps = 01 the next cycle;
   - set sensors 11 → pumps = 00, lead = 1;
   - next fill (sensors 00, 4 ticks later) → pumps = 10 first.
3. Sensors 10 during RUN_BOTH → next cycle: pumps = 00, alarm = 1, current_state = 100. Restore sensors 00 → IDLE, alarm = 0, and the restart waits the full 4 ticks.
4. Faults with lead = 0:
   - RUN_LEAD, pump_fault = 01 → pumps = 10 next cycle, lead stays 0;
   - then pump_fault = 11 → IDLE, pumps = 00, alarm = 1;
   - clear the faults → alarm = 0, restart after 4 ticks.
5. Assert reset asynchronously mid-RUN_BOTH → pumps = 00, lead = 0, current_state = 000 with no clock edge. After release, 4 ticks pass before the pumps restart.
6. Hysteresis and timebase:
   - IDLE with sensors 01 for 20 ticks → pumps stay 00;
   - sensors 00 with tick held low for 100 clocks → no start.
